// File: rtl/riscv_run_monitor_pkg.sv
// Shared types and defaults for the run monitor, so the program image and
// the monitor agree on the mailbox location and pass value.
package riscv_mon_pkg;

  typedef enum logic [2:0] {
    HOLD    = 3'd0,
    RUN     = 3'd1,
    PASS    = 3'd2,
    FAIL    = 3'd3,
    TIMEOUT = 3'd4
  } mon_state_t;

  localparam int unsigned DONE_ADDR_DEF  = 100;
  localparam int unsigned PASS_VALUE_DEF = 25;

endpackage

// File: rtl/riscv_run_monitor_if.sv
// Core-side snoop bundle: data-memory write port plus the retire pulse.
interface riscv_run_monitor_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              instr_retire;

  modport master (output mem_we, mem_addr, mem_wdata, instr_retire);
  modport slave  (input  mem_we, mem_addr, mem_wdata, instr_retire);
endinterface

// File: rtl/riscv_run_monitor_sat_counter.sv
// Up-counter with synchronous clear (priority over enable) that sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                      cnt_d = '0;
    else if (en_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/riscv_run_monitor.sv
// Run controller: sequences core reset, counts cycles/instret, and watches
// the mailbox store to report pass, fail or timeout.
module riscv_run_monitor
  import riscv_mon_pkg::*;
#(
  parameter int RST_CYCLES = 2,
  parameter int MAX_CYCLES = 1000,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 32,
  parameter int DONE_ADDR  = DONE_ADDR_DEF,
  parameter int PASS_VALUE = PASS_VALUE_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 restart,
  riscv_run_monitor_if.slave   mon,
  output logic                 core_reset,
  output logic                 running,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic                 timeout,
  output logic [DATA_W-1:0]    result,
  output logic [CNT_W-1:0]     cycle_count,
  output logic [CNT_W-1:0]     instret_count
);
  localparam int HW = $clog2(RST_CYCLES + 1);

  mon_state_t        state_q, state_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              hit, at_limit, clr;

  assign hit = mon.mem_we && (mon.mem_addr == ADDR_W'(DONE_ADDR));
  // Widen before comparing so a narrow counter never aliases a large budget.
  assign at_limit = (64'(cycle_count) == (64'(MAX_CYCLES) - 64'd1));
  assign clr      = restart && (state_q != HOLD);

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    result_d = result_q;
    unique case (state_q)
      HOLD: begin
        if (hold_q == HW'(RST_CYCLES)) begin
          state_d = RUN;
          hold_d  = '0;
        end else begin
          hold_d  = hold_q + 1'b1;
        end
      end
      RUN: begin
        if (restart) begin
          state_d  = HOLD;
          result_d = '0;
        end else if (hit) begin
          result_d = mon.mem_wdata;
          state_d  = (mon.mem_wdata == DATA_W'(PASS_VALUE)) ? PASS : FAIL;
        end else if (at_limit) begin
          state_d  = TIMEOUT;
        end
      end
      default: begin
        if (restart) begin
          state_d  = HOLD;
          result_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= HOLD;
      hold_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      result_q <= result_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_cyc (
    .clk(clk), .rst_n(reset_n), .clr_i(clr),
    .en_i(state_q == RUN), .cnt_o(cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_ret (
    .clk(clk), .rst_n(reset_n), .clr_i(clr),
    .en_i((state_q == RUN) && mon.instr_retire), .cnt_o(instret_count)
  );

  assign core_reset = (state_q == HOLD);
  assign running    = (state_q == RUN);
  assign pass       = (state_q == PASS);
  assign fail       = (state_q == FAIL);
  assign timeout    = (state_q == TIMEOUT);
  assign done       = pass || fail || timeout;
  assign result     = result_q;
endmodule

// File: tb/tb_riscv_run_monitor.sv
// Directed bench: main instance with a short timeout budget, plus a 4-bit
// counter instance for saturation.
module tb_riscv_run_monitor;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  // main instance
  logic        rst_n_a, restart_a;
  logic        core_reset_a, running_a, done_a, pass_a, fail_a, timeout_a;
  logic [31:0] result_a, cyc_a, ret_a;
  riscv_run_monitor_if #(.ADDR_W(32), .DATA_W(32)) mif_a ();

  riscv_run_monitor #(.RST_CYCLES(2), .MAX_CYCLES(10)) dut_a (
    .clk(clk), .reset_n(rst_n_a), .restart(restart_a), .mon(mif_a.slave),
    .core_reset(core_reset_a), .running(running_a), .done(done_a),
    .pass(pass_a), .fail(fail_a), .timeout(timeout_a), .result(result_a),
    .cycle_count(cyc_a), .instret_count(ret_a)
  );

  // saturation instance
  logic        rst_n_s, restart_s;
  logic        core_reset_s, running_s, done_s, pass_s, fail_s, timeout_s;
  logic [31:0] result_s;
  logic [3:0]  cyc_s, ret_s;
  riscv_run_monitor_if #(.ADDR_W(32), .DATA_W(32)) mif_s ();

  riscv_run_monitor #(.RST_CYCLES(2), .MAX_CYCLES(100), .CNT_W(4)) dut_s (
    .clk(clk), .reset_n(rst_n_s), .restart(restart_s), .mon(mif_s.slave),
    .core_reset(core_reset_s), .running(running_s), .done(done_s),
    .pass(pass_s), .fail(fail_s), .timeout(timeout_s), .result(result_s),
    .cycle_count(cyc_s), .instret_count(ret_s)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    mif_a.mem_we    = 1'b1;
    mif_a.mem_addr  = a;
    mif_a.mem_wdata = d;
    tick();
    mif_a.mem_we    = 1'b0;
  endtask

  // Pulse reset and step to the first RUN sample (cycle_count = 0).
  task automatic start_run();
    rst_n_a = 1'b0;
    #2;
    rst_n_a = 1'b1;
    tick(3);
  endtask

  task automatic test_reset();
    rst_n_a = 1'b0;
    tick(2);
    vecs++;
    if ({core_reset_a, running_a, done_a, pass_a, fail_a, timeout_a} !== 6'b100000) begin
      errs++; $display("FAIL reset_flags got=%b exp=100000",
        {core_reset_a, running_a, done_a, pass_a, fail_a, timeout_a});
    end
    vecs++;
    if ({result_a, cyc_a, ret_a} !== 96'd0) begin
      errs++; $display("FAIL reset_regs got res=%0d cyc=%0d ret=%0d exp=0", result_a, cyc_a, ret_a);
    end
    rst_n_a = 1'b1;
    for (int e = 1; e <= 2; e++) begin
      tick();
      vecs++;
      if (core_reset_a !== 1'b1 || running_a !== 1'b0) begin
        errs++; $display("FAIL reset_hold_edge%0d got core_reset=%b running=%b exp 1/0", e, core_reset_a, running_a);
      end
    end
    tick();
    vecs++;
    if (core_reset_a !== 1'b0 || running_a !== 1'b1 || cyc_a !== 32'd0) begin
      errs++; $display("FAIL reset_release got core_reset=%b running=%b cyc=%0d exp 0/1/0", core_reset_a, running_a, cyc_a);
    end
  endtask

  task automatic test_pass();
    start_run();
    mif_a.instr_retire = 1'b1;
    tick();
    mif_a.instr_retire = 1'b0;
    tick();
    wr(32'd100, 32'd25);
    vecs++;
    if ({pass_a, done_a, fail_a, running_a} !== 4'b1100 || result_a !== 32'd25) begin
      errs++; $display("FAIL pass_hit got p/d/f/r=%b result=%0d exp 1100 / 25",
        {pass_a, done_a, fail_a, running_a}, result_a);
    end
    vecs++;
    if (cyc_a !== 32'd3 || ret_a !== 32'd1) begin
      errs++; $display("FAIL pass_counts got cyc=%0d ret=%0d exp 3 / 1", cyc_a, ret_a);
    end
    mif_a.instr_retire = 1'b1;
    tick(2);
    mif_a.instr_retire = 1'b0;
    wr(32'd100, 32'd7);
    vecs++;
    if (result_a !== 32'd25 || pass_a !== 1'b1 || fail_a !== 1'b0 || cyc_a !== 32'd3 || ret_a !== 32'd1) begin
      errs++; $display("FAIL pass_frozen got res=%0d pass=%b fail=%b cyc=%0d ret=%0d exp 25/1/0/3/1",
        result_a, pass_a, fail_a, cyc_a, ret_a);
    end
  endtask

  task automatic test_fail();
    start_run();
    wr(32'd96, 32'd25);
    vecs++;
    if (done_a !== 1'b0 || running_a !== 1'b1 || result_a !== 32'd0) begin
      errs++; $display("FAIL decoy got done=%b running=%b res=%0d exp 0/1/0", done_a, running_a, result_a);
    end
    wr(32'd100, 32'd3);
    vecs++;
    if ({fail_a, pass_a, done_a} !== 3'b101 || result_a !== 32'd3) begin
      errs++; $display("FAIL fail_hit got f/p/d=%b res=%0d exp 101 / 3", {fail_a, pass_a, done_a}, result_a);
    end
  endtask

  task automatic test_timeout();
    start_run();
    tick(9);
    vecs++;
    if (running_a !== 1'b1 || timeout_a !== 1'b0 || cyc_a !== 32'd9) begin
      errs++; $display("FAIL timeout_pre got running=%b timeout=%b cyc=%0d exp 1/0/9", running_a, timeout_a, cyc_a);
    end
    tick();
    vecs++;
    if (timeout_a !== 1'b1 || done_a !== 1'b1 || cyc_a !== 32'd10) begin
      errs++; $display("FAIL timeout_hit got timeout=%b done=%b cyc=%0d exp 1/1/10", timeout_a, done_a, cyc_a);
    end
    tick(3);
    vecs++;
    if (cyc_a !== 32'd10 || timeout_a !== 1'b1) begin
      errs++; $display("FAIL timeout_frozen got cyc=%0d timeout=%b exp 10/1", cyc_a, timeout_a);
    end
  endtask

  task automatic test_race();
    start_run();
    tick(9);
    wr(32'd100, 32'd25);
    tick();
    vecs++;
    if (pass_a !== 1'b1 || timeout_a !== 1'b0 || cyc_a !== 32'd10) begin
      errs++; $display("FAIL race got pass=%b timeout=%b cyc=%0d exp 1/0/10", pass_a, timeout_a, cyc_a);
    end
  endtask

  task automatic test_restart();
    restart_a = 1'b1;
    tick();
    restart_a = 1'b0;
    vecs++;
    if ({core_reset_a, done_a, pass_a, running_a} !== 4'b1000 || cyc_a !== 32'd0 || result_a !== 32'd0) begin
      errs++; $display("FAIL restart_clear got cr/d/p/r=%b cyc=%0d res=%0d exp 1000/0/0",
        {core_reset_a, done_a, pass_a, running_a}, cyc_a, result_a);
    end
    tick(2);
    vecs++;
    if (core_reset_a !== 1'b1) begin
      errs++; $display("FAIL restart_hold got core_reset=%b exp 1", core_reset_a);
    end
    tick();
    vecs++;
    if (core_reset_a !== 1'b0 || running_a !== 1'b1 || cyc_a !== 32'd0) begin
      errs++; $display("FAIL restart_run got core_reset=%b running=%b cyc=%0d exp 0/1/0", core_reset_a, running_a, cyc_a);
    end
    tick();
    vecs++;
    if (cyc_a !== 32'd1) begin
      errs++; $display("FAIL restart_count got cyc=%0d exp 1", cyc_a);
    end
  endtask

  task automatic test_async_reset();
    start_run();
    tick(2);
    wr(32'd100, 32'd25);
    rst_n_a = 1'b0;
    #2;
    vecs++;
    if ({core_reset_a, running_a, done_a, pass_a} !== 4'b1000 || cyc_a !== 32'd0 || result_a !== 32'd0) begin
      errs++; $display("FAIL async_reset got cr/r/d/p=%b cyc=%0d res=%0d exp 1000/0/0",
        {core_reset_a, running_a, done_a, pass_a}, cyc_a, result_a);
    end
    rst_n_a = 1'b1;
  endtask

  task automatic test_saturation();
    mif_s.instr_retire = 1'b1;
    rst_n_s = 1'b1;
    tick(3);
    tick(15);
    vecs++;
    if (cyc_s !== 4'd15 || ret_s !== 4'd15) begin
      errs++; $display("FAIL sat_reach got cyc=%0d ret=%0d exp 15/15", cyc_s, ret_s);
    end
    tick(5);
    vecs++;
    if (cyc_s !== 4'd15 || ret_s !== 4'd15 || running_s !== 1'b1 || timeout_s !== 1'b0) begin
      errs++; $display("FAIL sat_hold got cyc=%0d ret=%0d running=%b timeout=%b exp 15/15/1/0",
        cyc_s, ret_s, running_s, timeout_s);
    end
  endtask

  initial begin
    rst_n_a = 1'b0; restart_a = 1'b0;
    mif_a.mem_we = 1'b0; mif_a.mem_addr = '0; mif_a.mem_wdata = '0; mif_a.instr_retire = 1'b0;
    rst_n_s = 1'b0; restart_s = 1'b0;
    mif_s.mem_we = 1'b0; mif_s.mem_addr = '0; mif_s.mem_wdata = '0; mif_s.instr_retire = 1'b0;
    #1;
    test_reset();
    test_pass();
    test_fail();
    test_timeout();
    test_race();
    test_restart();
    test_async_reset();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
